wb_master: RTL

Wishbone classic single-transfer master: the initiator end of the Wishbone slave port on the SPI controller. It accepts one read or write command at a time on a local valid/ready interface and runs one classic bus cycle (CYC/STB held until ACK). It returns a response holding read data and an error flag. It drives the SPI controller's register window from a local sequencer or CPU-side bridge and serves as the bus-functional master for bench reuse.

---
 rtl/wb_pkg.sv | 28 ++
 rtl/wb_wait_timer.sv | 39 +++
 rtl/wb_master.sv | 139 +++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
//------------------------------------------------------------------------------
// Module   : wb_pkg
// Purpose  : Shared types and default constants for the Wishbone master slice.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package wb_pkg;

  // Master FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  localparam int WB_ADR_W       = 8;
  localparam int WB_DAT_W       = 32;
  localparam int WB_TIMEOUT_DEF = 255;

  // Width of a counter that must be able to hold the value 'max_val'
  function automatic int wb_cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_wait_timer.sv
//------------------------------------------------------------------------------
// Module   : wb_wait_timer
// Purpose  : Saturating up-counter with synchronous clear and enable. tc_o is
//            high while the count sits one below MAX, so an enabled edge in
//            that state is the edge on which the count reaches MAX.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_wait_timer import wb_pkg::*; #(
  parameter int MAX = WB_TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int W = wb_cnt_w(MAX);

  logic [W-1:0] cnt_q;

  // Counter register: clear wins over enable, holds once MAX is reached
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != W'(MAX))) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc_o = (cnt_q == W'(MAX - 1));

endmodule

`default_nettype wire

// File: rtl/wb_master.sv
//------------------------------------------------------------------------------
// Module   : wb_master
// Purpose  : Wishbone classic single-transfer master with a valid/ready command
//            port and a valid/ready response port.
// Options  : WB_MASTER_TIMEOUT_EN - abort a bus cycle after TIMEOUT wait cycles
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_master import wb_pkg::*; #(
  parameter int ADR_W   = WB_ADR_W,
  parameter int DAT_W   = WB_DAT_W,
  parameter int TIMEOUT = WB_TIMEOUT_DEF
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [ADR_W-1:0] cmd_adr,
  input  logic [DAT_W-1:0] cmd_dat,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DAT_W-1:0] rsp_dat,
  output logic             rsp_err,
  output logic [ADR_W-1:0] ADR_O,
  output logic [DAT_W-1:0] DAT_O,
  input  logic [DAT_W-1:0] DAT_I,
  output logic             WE_O,
  output logic             CYC_O,
  output logic             STB_O,
  input  logic             ACK_I
);

  wb_state_e        state_q, state_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [DAT_W-1:0] dat_q, dat_d;
  logic             we_q, we_d;
  logic [DAT_W-1:0] rdat_q, rdat_d;
  logic             err_q, err_d;
  logic             tmr_clr;
  logic             tmr_en;
  logic             w_timeout;

`ifdef WB_MASTER_TIMEOUT_EN
  wb_wait_timer #(
    .MAX (TIMEOUT)
  ) u_wait_timer (
    .clk_i (CLK_I),
    .rst_i (RST_I),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .tc_o  (w_timeout)
  );
`else
  // No timer: the bus cycle waits for ACK_I indefinitely
  logic w_unused_timer;
  assign w_unused_timer = tmr_clr ^ tmr_en ^ (TIMEOUT != 0);
  assign w_timeout      = 1'b0;
`endif

  // State and output registers; reset abandons any bus cycle immediately
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; ACK_I has priority over the timeout on the same edge
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          we_d    = cmd_we;
          tmr_clr = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        if (ACK_I) begin
          rdat_d  = we_q ? '0 : DAT_I;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (w_timeout) begin
          rdat_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tmr_en  = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign CYC_O     = (state_q == BUS);
  assign STB_O     = (state_q == BUS);
  assign ADR_O     = adr_q;
  assign DAT_O     = dat_q;
  assign WE_O      = we_q;
  assign rsp_dat   = rdat_q;
`ifdef WB_MASTER_TIMEOUT_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

`default_nettype wire
